// File: rtl/cryosram_tester_top.sv
// -----------------------------------------------------------------------------
// cryosram_tester_top
//   Board-level controller that exercises an external 8-bit asynchronous SRAM
//   from switches and buttons. Debounced buttons latch an address and a write
//   value, or launch a write or read cycle. Each phase of a cycle lasts one
//   period of a programmable strobe divider. The last read value and the
//   current settings are shown on LEDs and on a 4-digit 7-segment display.
//
// Ports
//   clk       system clock, every register on the rising edge
//   btnT      synchronous active-low reset (0 = reset)
//   btnC      load write data from sw[7:0]
//   btnL      start SRAM read
//   btnR      start SRAM write (wins over btnL in the same cycle)
//   btnD      load address from sw[7:0]
//   sw[15:0]  [7:0] value, [14] rising edge loads clk_factor, [15] display select
//   led[15:0] [7:0] last read data, [15] busy, [14:8] zero
//   segment   active-low segments, bit 0 = a ... bit 6 = g
//   dp        decimal point, always off (1)
//   digit     active-low digit enables, digit[3] is the leftmost digit
//   JA / JB   SRAM address / SRAM write data
//   JC        SRAM read data
//   JXADC     {3'b0, tick, busy, oe_n, we_n, ce_n}
//   debug     {state[3:0], clk_factor, addr, rdata}
// -----------------------------------------------------------------------------
module cryosram_tester_top #(
  parameter int DEBOUNCE_DELAY = 1000000,
  parameter int REFRESH_BITS   = 16
) (
  input  logic        clk,
  input  logic        btnT,
  input  logic        btnC,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnD,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [6:0]  segment,
  output logic        dp,
  output logic [3:0]  digit,
  output logic [7:0]  JA,
  output logic [7:0]  JB,
  input  logic [7:0]  JC,
  output logic [7:0]  JXADC,
  output logic [27:0] debug
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    W_SETUP  = 4'd1,
    W_PULSE  = 4'd2,
    W_HOLD   = 4'd3,
    R_SETUP  = 4'd4,
    R_SAMPLE = 4'd5
  } state_t;

  localparam int                DB_W   = $clog2(DEBOUNCE_DELAY + 1);
  localparam logic [DB_W-1:0]   DB_MAX = DB_W'(DEBOUNCE_DELAY);
  localparam int                RW     = REFRESH_BITS + 2;

  // ---------------------------------------------------------------------------
  // Debounce: one pulse when a button has been high for DEBOUNCE_DELAY cycles.
  // The counter saturates, so a held button never pulses a second time.
  // ---------------------------------------------------------------------------
  logic [3:0]      btn;
  logic [DB_W-1:0] db_cnt [4];
  logic [3:0]      btn_pulse;
  logic            pulse_c, pulse_l, pulse_r, pulse_d;

  assign btn = {btnD, btnR, btnL, btnC};

  // NOTE: the debounce counters form an array but are ordinary flops, so they
  // are cleared by reset like every other register here.
  always_ff @(posedge clk) begin
    if (!btnT) begin
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      btn_pulse <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!btn[i])                 db_cnt[i] <= '0;
        else if (db_cnt[i] != DB_MAX) db_cnt[i] <= db_cnt[i] + 1'b1;
        btn_pulse[i] <= btn[i] && (db_cnt[i] == DB_MAX - 1'b1);
      end
    end
  end

  assign {pulse_d, pulse_r, pulse_l, pulse_c} = btn_pulse;

  // ---------------------------------------------------------------------------
  // Settings, strobe divider, access FSM state, display refresh
  // ---------------------------------------------------------------------------
  state_t      state, state_nx;
  logic        sw14_q;
  logic [7:0]  clk_factor, addr, wdata, rdata;
  logic [7:0]  acc_addr, acc_wdata;   // operands frozen at access launch
  logic [7:0]  div_cnt;
  logic [RW-1:0] refresh_cnt;
  logic        tick;

  // >= rather than == keeps the period bounded if clk_factor is lowered
  // while the divider is already past the new limit.
  assign tick = (div_cnt >= clk_factor);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!btnT) begin
      state       <= IDLE;
      sw14_q      <= 1'b0;
      clk_factor  <= '0;
      addr        <= '0;
      wdata       <= '0;
      rdata       <= '0;
      acc_addr    <= '0;
      acc_wdata   <= '0;
      div_cnt     <= '0;
      refresh_cnt <= '0;
    end else begin
      state       <= state_nx;
      sw14_q      <= sw[14];
      div_cnt     <= tick ? 8'd0 : div_cnt + 8'd1;
      refresh_cnt <= refresh_cnt + 1'b1;
      if (sw[14] && !sw14_q) clk_factor <= sw[7:0];
      if (pulse_d)           addr       <= sw[7:0];
      if (pulse_c)           wdata      <= sw[7:0];
      if (state == IDLE && state_nx != IDLE) begin
        acc_addr  <= addr;
        acc_wdata <= wdata;
      end
      if (state == R_SAMPLE && tick) rdata <= JC;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (pulse_r)      state_nx = W_SETUP;
        else if (pulse_l) state_nx = R_SETUP;
      end
      W_SETUP:  if (tick) state_nx = W_PULSE;
      W_PULSE:  if (tick) state_nx = W_HOLD;
      W_HOLD:   if (tick) state_nx = IDLE;
      R_SETUP:  if (tick) state_nx = R_SAMPLE;
      R_SAMPLE: if (tick) state_nx = IDLE;
      default:            state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // SRAM bus drive, decoded from state
  // ---------------------------------------------------------------------------
  logic ce_n, we_n, oe_n, busy;

  // NOTE: every output gets a default before the case, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ce_n = 1'b1;
    we_n = 1'b1;
    oe_n = 1'b1;
    JA   = addr;
    JB   = 8'h00;
    case (state)
      W_SETUP, W_HOLD: begin
        ce_n = 1'b0;
        JA   = acc_addr;
        JB   = acc_wdata;
      end
      W_PULSE: begin
        ce_n = 1'b0;
        we_n = 1'b0;
        JA   = acc_addr;
        JB   = acc_wdata;
      end
      R_SETUP, R_SAMPLE: begin
        ce_n = 1'b0;
        oe_n = 1'b0;
        JA   = acc_addr;
      end
      default: ;
    endcase
  end

  assign busy  = (state != IDLE);
  assign led   = {busy, 7'b0, rdata};
  assign JXADC = {3'b000, tick, busy, oe_n, we_n, ce_n};
  assign debug = {state, clk_factor, addr, rdata};

  // ---------------------------------------------------------------------------
  // 7-segment display: top two refresh bits pick the digit, 3 = leftmost
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  logic [1:0]  digit_sel;
  logic [15:0] disp_word;
  logic [3:0]  disp_nib;

  assign digit_sel = refresh_cnt[RW-1 -: 2];
  assign disp_word = sw[15] ? {clk_factor, rdata} : {addr, wdata};
  assign disp_nib  = disp_word[{digit_sel, 2'b00} +: 4];
  assign segment   = hex_glyph(disp_nib);
  assign digit     = ~(4'b0001 << digit_sel);
  assign dp        = 1'b1;

  // sw[13:8] have no function on this board.
  logic unused_sw;
  assign unused_sw = ^sw[13:8];

endmodule

// File: tb/tb_cryosram_tester_top.sv
module tb_cryosram_tester_top;

  localparam int RB = 2;

  logic        clk = 1'b0;
  logic        btnT, btnC, btnL, btnR, btnD;
  logic [15:0] sw;
  logic [7:0]  JC;
  logic [15:0] led;
  logic [6:0]  segment;
  logic        dp;
  logic [3:0]  digit;
  logic [7:0]  JA, JB, JXADC;
  logic [27:0] debug;

  always #5 clk = ~clk;

  cryosram_tester_top #(.DEBOUNCE_DELAY(1), .REFRESH_BITS(RB)) dut (
    .clk(clk), .btnT(btnT), .btnC(btnC), .btnL(btnL), .btnR(btnR), .btnD(btnD),
    .sw(sw), .led(led), .segment(segment), .dp(dp), .digit(digit),
    .JA(JA), .JB(JB), .JC(JC), .JXADC(JXADC), .debug(debug)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [27:0] glyphs;   // {leftmost .. rightmost}, 7 bits each
  } disp_vec_t;

  disp_vec_t vecs[4];

  int ce_lo, we_lo, oe_lo, bad_bus, bad_scan, gap, nticks;
  logic [27:0] glyphs;
  bit found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press_load(input bit is_addr, input logic [7:0] val);
    sw[7:0] = val;
    if (is_addr) btnD = 1'b1; else btnC = 1'b1;
    repeat (2) @(negedge clk);
    btnD = 1'b0;
    btnC = 1'b0;
    @(negedge clk);
  endtask

  task automatic capture_display(output logic [27:0] g, output int bad);
    bit hit;
    bad = 0;
    g   = '0;
    for (int d = 3; d >= 0; d--) begin
      hit = 1'b0;
      for (int i = 0; i < 64 && !hit; i++) begin
        @(negedge clk);
        if ($countones(~digit) != 1) bad++;
        if (digit == ~(4'b0001 << d)) begin
          hit = 1'b1;
          g[d*7 +: 7] = segment;
        end
      end
      if (!hit) bad++;
    end
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (JXADC[4]) seen = 1'b1;
    end
    check("tick_seen", 32'(seen), 32'd1);
  endtask

  // rl = {btnR, btnL}. With align set, the launch is placed so the first
  // access phase starts right after a tick and therefore lasts a full period.
  task automatic run_access(input logic [1:0] rl, input bit align,
                            input logic [7:0] exp_ja, input logic [7:0] exp_jb,
                            output int ce_c, output int we_c, output int oe_c,
                            output int bad_c);
    bit seen_busy, done;
    logic [7:0] exp_rd;
    ce_c = 0; we_c = 0; oe_c = 0; bad_c = 0;
    seen_busy = 1'b0;
    done      = 1'b0;
    if (align) begin
      wait_tick();
      repeat (2) @(negedge clk);
    end
    if (rl == 2'b01) sb_q.push_back(JC);
    btnR = rl[1];
    btnL = rl[0];
    @(negedge clk);
    btnR = 1'b0;
    btnL = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!JXADC[0]) begin
        ce_c++;
        if (JA !== exp_ja || JB !== exp_jb) bad_c++;
      end
      if (!JXADC[1]) we_c++;
      if (!JXADC[2]) oe_c++;
      if (led[15]) seen_busy = 1'b1;
      else if (seen_busy) done = 1'b1;
    end
    check("access_done", 32'(done), 32'd1);
    if (rl == 2'b01) begin
      if (sb_q.size() == 0) check("sb_nonempty", 32'd0, 32'd1);
      else begin
        exp_rd = sb_q.pop_front();
        check("rdata_led", 32'(led[7:0]), 32'(exp_rd));
      end
    end
  endtask

  initial begin
    vecs[0] = '{"disp_0123", 8'h01, 8'h23, {7'h40, 7'h79, 7'h24, 7'h30}};
    vecs[1] = '{"disp_4567", 8'h45, 8'h67, {7'h19, 7'h12, 7'h02, 7'h78}};
    vecs[2] = '{"disp_89ab", 8'h89, 8'hab, {7'h00, 7'h10, 7'h08, 7'h03}};
    vecs[3] = '{"disp_cdef", 8'hcd, 8'hef, {7'h46, 7'h21, 7'h06, 7'h0e}};

    btnT = 1'b0; btnC = 1'b0; btnL = 1'b0; btnR = 1'b0; btnD = 1'b0;
    sw = 16'h0000;
    JC = 8'h00;

    // Reset state
    repeat (10) @(negedge clk);
    check("rst_led",   32'(led),   32'h0000);
    check("rst_ja",    32'(JA),    32'h00);
    check("rst_jb",    32'(JB),    32'h00);
    check("rst_jxadc", 32'(JXADC), 32'h17);
    check("rst_debug", 32'(debug), 32'h0);
    check("rst_digit", 32'(digit), 32'he);
    check("rst_dp",    32'(dp),    32'h1);
    btnT = 1'b1;
    @(negedge clk);

    // Held btnD: one load only, later switch changes must not reload
    sw = 16'h00cd;
    btnD = 1'b1;
    repeat (3) @(negedge clk);
    sw = 16'h0011;
    repeat (7) @(negedge clk);
    btnD = 1'b0;
    @(negedge clk);
    check("hold_addr", 32'(debug[15:8]), 32'hcd);
    check("hold_ja",   32'(JA),          32'hcd);

    // Display table, sw[15] = 0 shows addr/wdata
    sw = 16'h0000;
    for (int v = 0; v < 4; v++) begin
      press_load(1'b1, vecs[v].addr);
      press_load(1'b0, vecs[v].wdata);
      capture_display(glyphs, bad_scan);
      check(vecs[v].name, 32'(glyphs), 32'(vecs[v].glyphs));
      check({vecs[v].name, "_scan"}, 32'(bad_scan), 32'd0);
    end

    // clk_factor from sw[14] rising edge
    sw = 16'h0002;
    @(negedge clk);
    sw = 16'h4002;
    @(negedge clk);
    sw = 16'h0002;
    @(negedge clk);
    check("clk_factor", 32'(debug[23:16]), 32'h02);
    wait_tick();
    gap = 0;
    found = 1'b0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (JXADC[4]) begin found = 1'b1; gap = i; end
    end
    check("tick_gap", 32'(gap), 32'd3);
    nticks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (JXADC[4]) nticks++;
    end
    check("tick_count30", 32'(nticks), 32'd10);

    sw = 16'h8002;
    capture_display(glyphs, bad_scan);
    check("disp_0200", 32'(glyphs), 32'({7'h40, 7'h24, 7'h40, 7'h40}));

    // Write with clk_factor 2
    run_access(2'b10, 1'b1, 8'hcd, 8'hef, ce_lo, we_lo, oe_lo, bad_bus);
    check("wr_ce_lo",  32'(ce_lo),   32'd9);
    check("wr_we_lo",  32'(we_lo),   32'd3);
    check("wr_oe_lo",  32'(oe_lo),   32'd0);
    check("wr_bus",    32'(bad_bus), 32'd0);
    check("wr_busy",   32'(led[15]), 32'd0);

    // Read with clk_factor 2
    JC = 8'hab;
    run_access(2'b01, 1'b1, 8'hcd, 8'h00, ce_lo, we_lo, oe_lo, bad_bus);
    check("rd_oe_lo", 32'(oe_lo),   32'd6);
    check("rd_ce_lo", 32'(ce_lo),   32'd6);
    check("rd_we_lo", 32'(we_lo),   32'd0);
    check("rd_bus",   32'(bad_bus), 32'd0);
    check("rd_debug", 32'(debug[7:0]), 32'hab);
    capture_display(glyphs, bad_scan);
    check("disp_02ab", 32'(glyphs), 32'({7'h40, 7'h24, 7'h08, 7'h03}));

    // Reset in the middle of W_PULSE
    wait_tick();
    repeat (2) @(negedge clk);
    btnR = 1'b1;
    @(negedge clk);
    btnR = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!JXADC[1]) found = 1'b1;
    end
    check("we_pulse_seen", 32'(found), 32'd1);
    btnT = 1'b0;
    @(negedge clk);
    check("abort_ctrl",  32'(JXADC[3:0]), 32'h7);
    check("abort_led",   32'(led),        32'h0000);
    check("abort_debug", 32'(debug),      32'h0);
    check("abort_ja",    32'(JA),         32'h00);
    check("abort_jb",    32'(JB),         32'h00);
    btnT = 1'b1;
    sw = 16'h0000;
    capture_display(glyphs, bad_scan);
    check("disp_0000", 32'(glyphs), 32'({7'h40, 7'h40, 7'h40, 7'h40}));

    // clk_factor is 0 again: every phase lasts one cycle
    press_load(1'b1, 8'h80);
    JC = 8'hff;
    run_access(2'b01, 1'b0, 8'h80, 8'h00, ce_lo, we_lo, oe_lo, bad_bus);
    check("rd80_oe_lo", 32'(oe_lo),   32'd2);
    check("rd80_bus",   32'(bad_bus), 32'd0);

    press_load(1'b1, 8'h00);
    check("idle_ja_00", 32'(JA), 32'h00);
    press_load(1'b0, 8'h5a);
    run_access(2'b10, 1'b0, 8'h00, 8'h5a, ce_lo, we_lo, oe_lo, bad_bus);
    check("wr00_ce_lo", 32'(ce_lo),   32'd3);
    check("wr00_we_lo", 32'(we_lo),   32'd1);
    check("wr00_bus",   32'(bad_bus), 32'd0);

    press_load(1'b1, 8'h80);
    check("idle_ja_80", 32'(JA), 32'h80);
    JC = 8'h3c;
    run_access(2'b01, 1'b0, 8'h80, 8'h00, ce_lo, we_lo, oe_lo, bad_bus);
    check("rd80b_oe_lo", 32'(oe_lo),   32'd2);
    check("rd80b_bus",   32'(bad_bus), 32'd0);

    // Write and read launched together: write wins
    run_access(2'b11, 1'b0, 8'h80, 8'h5a, ce_lo, we_lo, oe_lo, bad_bus);
    check("both_we_lo", 32'(we_lo),   32'd1);
    check("both_oe_lo", 32'(oe_lo),   32'd0);
    check("both_ce_lo", 32'(ce_lo),   32'd3);
    check("both_bus",   32'(bad_bus), 32'd0);
    check("both_rdata", 32'(led[7:0]), 32'h3c);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cryosram_tester_top.md
Name: cryosram_tester_top

Overview:
Board-level controller for exercising an external 8-bit SRAM from switches and buttons.
- Debounced buttons latch an address and a write value.
- Further buttons launch a write or read cycle to the SRAM, paced by a programmable strobe divider.
- The last read value and settings appear on LEDs and a 4-digit 7-segment display.

Parameters:
DEBOUNCE_DELAY, 1000000, consecutive clk cycles a button must read high before it is accepted (benches use 1)
REFRESH_BITS, 16, 7-seg digit dwell = 2^REFRESH_BITS clk cycles

Ports:
clk  in  1  system clock; all logic on rising edge
btnT  in  1  synchronous active-low reset (0 = reset)
btnC  in  1  load write data from sw[7:0]
btnL  in  1  start SRAM read
btnR  in  1  start SRAM write
btnD  in  1  load address from sw[7:0]
sw  in  16  [7:0] value, [14] load clk_factor, [15] display select
led  out  16  [7:0] rdata, [15] busy, [14:8] 0
segment  out  7  active-low segments a..g = bits 0..6
dp  out  1  decimal point, constant 1 (off)
digit  out  4  active-low digit enables, digit[3] = leftmost
JA  out  8  SRAM address
JB  out  8  SRAM write data
JC  in  8  SRAM read data
JXADC  out  8  [0] ce_n, [1] we_n, [2] oe_n, [3] busy, [4] tick, [7:5] 0
debug  out  28  {state[3:0], clk_factor, addr, rdata}, simulation aid

Behaviour:
- Reset (btnT low at a clk edge) clears addr, wdata, clk_factor, rdata, divider and refresh counters to 0.
  - FSM goes to IDLE; ce_n, we_n, oe_n = 1; JA = JB = 0; outputs valid from the next cycle.
  - Reset mid-cycle aborts the SRAM access immediately.
- Debounce, per button btnC/L/R/D:
  - Counter runs while the input is 1 and clears when it is 0.
  - When the count reaches DEBOUNCE_DELAY, emit one single-cycle pulse; no further pulse until the input has returned to 0.
- sw[14]: rising edge (registered previous value) loads clk_factor <= sw[7:0]. No debounce is applied.
- btnD pulse: addr <= sw[7:0]. btnC pulse: wdata <= sw[7:0]. Both are allowed at any time; an access in progress uses the values latched at its start.
- tick: one-cycle pulse every (clk_factor+1) clk cycles (clk_factor 0 gives a tick every cycle). The divider runs freely.
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_SAMPLE.
  - State advances only on tick, except IDLE, which leaves on a button pulse.
  - btnR pulse in IDLE → W_SETUP. btnL pulse in IDLE → R_SETUP. If both arrive in the same cycle, the write wins. Pulses outside IDLE are ignored.
- Write sequence:
  - W_SETUP: JA=addr, JB=wdata, ce_n=0, we_n=1, oe_n=1.
  - W_PULSE: as W_SETUP but we_n=0.
  - W_HOLD: we_n=1, addr and data still driven.
  - Then IDLE.
- Read sequence:
  - R_SETUP: JA=addr, ce_n=0, oe_n=0, JB=0.
  - R_SAMPLE: same drive; on the tick that leaves this state, rdata <= JC. Then IDLE.
- In IDLE: ce_n=we_n=oe_n=1, JA=addr, JB=0.
- busy = (state != IDLE).
- Display, 4 hex digits, left to right:
  - sw[15]=0: addr[7:4], addr[3:0], wdata[7:4], wdata[3:0].
  - sw[15]=1: clk_factor[7:4], clk_factor[3:0], rdata[7:4], rdata[3:0].
  - Digits are scanned by a refresh counter; exactly one digit bit is low at a time.
  - Standard hex glyphs; for example 0 = 7'b1000000 and A = 7'b0001000 (bits g..a).

Test Plan:
- DEBOUNCE_DELAY=1, btnT low 10 cycles then high; sw=0x00cd, btnD held 10 cycles → addr=0xcd, JA=0xcd, exactly one load pulse.
- sw=0x00ef, btnC pulse → wdata=0xef; with sw[15]=0 the display scans CDEF.
- sw=0x0002, then toggle sw[14] → clk_factor=2, tick every 3 cycles; with sw[15]=1 the display shows 0200.
- btnR pulse → ce_n low 9 cycles, we_n low exactly 3 cycles, JA=0xcd, JB=0xef throughout, busy then returns to 0.
- JC=0xab, btnL pulse → oe_n low 6 cycles, rdata=0xab, led[7:0]=0xab, display (sw[15]=1) 02AB.
- Assert btnT during W_PULSE → next cycle IDLE, we_n=1, all registers 0. Then: address 0x80 read returns JC=0xff; re-latch addr 0x00 and write; return to 0x80 and read → JA tracks addr exactly, no stale bits.
